// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
//
// Shares one 4-digit multiplexed seven-segment display between N_REQ
// requesters. Each requester supplies a 4-digit BCD word. A free-running scan
// steps through the four digit slots. The first BLANK_CYC cycles of every slot
// keep all anodes off, so the previous digit's segments do not ghost into the
// next digit.
//
// Ownership can change only on the frame boundary, which is the last cycle of
// digit slot 3. The owner's word is latched at that same edge. As a result a
// frame always shows one consistent word, and changes that the owner makes to
// its data mid-frame become visible at the next frame.
//
// Arbitration is round-robin:
//   - An owner keeps the display for SLICE_FRAMES frames while others wait.
//   - It keeps the display indefinitely when nobody else is asking.
//   - When the owner drops its request, ownership passes at the next boundary
//     to the next requester, with no idle frame in between.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   req         per-requester ownership request (level, sampled at boundary)
//   data        requester i word at [16i+15:16i]; nibble 0 = rightmost digit
//   grant       one-hot current owner, zero when idle
//   digit_bcd   BCD nibble of the active digit, to the segment decoder
//   an          anode enables, active-low
//   dp          decimal point, active-low, held off
//   frame_tick  one-cycle pulse in the last cycle of every frame
// -----------------------------------------------------------------------------
module seg_display_scheduler #(
  parameter int N_REQ        = 4,
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYC    = 500,
  parameter int SLICE_FRAMES = 200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  data,
  output logic [N_REQ-1:0]     grant,
  output logic [3:0]           digit_bcd,
  output logic [3:0]           an,
  output logic                 dp,
  output logic                 frame_tick
);

  localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = $clog2(N_REQ);
  localparam int SLICE_W = (SLICE_FRAMES > 1) ? $clog2(SLICE_FRAMES) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0]   BLANK_END  = DIV_W'(BLANK_CYC);
  localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(SLICE_FRAMES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_OWN
  } state_t;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t             state_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [1:0]         digit_reg;
  logic [SLICE_W-1:0] slice_cnt_reg;
  logic [N_REQ-1:0]   grant_reg;
  logic [IDX_W-1:0]   owner_reg;
  logic [IDX_W-1:0]   rr_ptr_reg;
  logic [15:0]        word_reg;

  // ---------------------------------------------------------------------------
  // Requester words split out for indexed selection
  // ---------------------------------------------------------------------------
  logic [15:0] data_word [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data_word
    assign data_word[gi] = data[16*gi +: 16];
  end

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  logic div_last;
  logic boundary;

  assign div_last = (div_cnt_reg == DIV_LAST);
  assign boundary = div_last && (digit_reg == 2'd3);

  // ---------------------------------------------------------------------------
  // Round-robin search
  //
  // The search starts at the rr pointer. While a requester owns the display,
  // the pointer already sits one past the owner, so the same search gives
  // "next requester after the owner" once the owner's own bit is masked out.
  // In IDLE it gives "first requester at or after the pointer".
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] cand;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_rr_next;
  int               cand_idx;

  assign cand = (state_reg == ST_OWN) ? (req & ~grant_reg) : req;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_idx = int'(rr_ptr_reg) + k;
      if (cand_idx >= N_REQ) begin
        cand_idx = cand_idx - N_REQ;
      end
      if (!pick_found && cand[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand_idx);
      end
    end
  end

  assign pick_onehot  = N_REQ'(1) << pick_idx;
  assign pick_rr_next = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;

  // ---------------------------------------------------------------------------
  // Boundary decisions
  //
  // take_new : hand the display to pick_idx.
  //            This happens from IDLE, after the owner drops its request, or
  //            when the slice expires and someone else is waiting.
  // go_idle  : the owner dropped its request and nobody else wants the
  //            display.
  //
  // A drop that coincides with slice expiry is handled as a drop. Both cases
  // lead to the same search, so no special priority logic is needed.
  // ---------------------------------------------------------------------------
  logic owner_req;
  logic slice_last;
  logic take_new;
  logic go_idle;

  assign owner_req  = req[owner_reg];
  assign slice_last = (slice_cnt_reg == SLICE_LAST);
  assign take_new   = pick_found &&
                      ((state_reg == ST_IDLE) || !owner_req || slice_last);
  assign go_idle    = (state_reg == ST_OWN) && !owner_req && !pick_found;

  // ---------------------------------------------------------------------------
  // Scan counter, arbitration FSM and word latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      div_cnt_reg   <= '0;
      digit_reg     <= 2'd0;
      slice_cnt_reg <= '0;
      grant_reg     <= '0;
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      word_reg      <= '0;
    end else begin
      // Free-running scan, independent of ownership.
      if (div_last) begin
        div_cnt_reg <= '0;
        digit_reg   <= digit_reg + 2'd1;
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end

      if (boundary) begin
        case (state_reg)
          ST_IDLE: begin
            if (take_new) begin
              state_reg     <= ST_OWN;
              owner_reg     <= pick_idx;
              grant_reg     <= pick_onehot;
              rr_ptr_reg    <= pick_rr_next;
              slice_cnt_reg <= '0;
              word_reg      <= data_word[pick_idx];
            end else begin
              word_reg      <= '0;
            end
          end

          ST_OWN: begin
            if (take_new) begin
              owner_reg     <= pick_idx;
              grant_reg     <= pick_onehot;
              rr_ptr_reg    <= pick_rr_next;
              slice_cnt_reg <= '0;
              word_reg      <= data_word[pick_idx];
            end else if (go_idle) begin
              state_reg     <= ST_IDLE;
              grant_reg     <= '0;
              slice_cnt_reg <= '0;
              word_reg      <= '0;
            end else begin
              // The owner keeps the display.
              // If the slice expired with nobody waiting, start a fresh slice.
              slice_cnt_reg <= slice_last ? '0 : slice_cnt_reg + 1'b1;
              word_reg      <= data_word[owner_reg];
            end
          end

          default: begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registered state only)
  // ---------------------------------------------------------------------------
  logic       lit;
  logic [3:0] nibble [4];

  assign lit = (|grant_reg) && (div_cnt_reg >= BLANK_END);

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign nibble[gi] = word_reg[4*gi +: 4];
    assign an[gi]     = ~(lit && (digit_reg == 2'(gi)));
  end

  assign grant      = grant_reg;
  assign digit_bcd  = nibble[digit_reg];
  assign dp         = 1'b1;
  assign frame_tick = boundary;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// tb_seg_display_scheduler
//
// Drives seg_display_scheduler with small scan parameters.
//
// The reference model tracks the position inside the frame as a plain cycle
// index and the owner as an integer (-1 = idle). On every frame boundary it
// applies the arbitration rules with modular arithmetic. Every cycle, all
// outputs are compared against the model.
//
// Directed sequences walk through each scenario of the test plan. A long
// randomized run follows.
// -----------------------------------------------------------------------------
module tb_seg_display_scheduler;

  localparam int N_REQ        = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int SLICE_FRAMES = 2;
  localparam int FRAME        = 4 * SCAN_DIV;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_REQ-1:0]     req = '0;
  logic [16*N_REQ-1:0]  data = '0;
  logic [N_REQ-1:0]     grant;
  logic [3:0]           digit_bcd;
  logic [3:0]           an;
  logic                 dp;
  logic                 frame_tick;

  seg_display_scheduler #(
    .N_REQ       (N_REQ),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYC   (BLANK_CYC),
    .SLICE_FRAMES(SLICE_FRAMES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .grant     (grant),
    .digit_bcd (digit_bcd),
    .an        (an),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  string phase  = "reset";

  // Reference model state
  int          m_t;      // cycle index within the frame, 0..FRAME-1
  int          m_owner;  // -1 when idle
  int          m_slice;
  int          m_rr;
  logic [15:0] m_word;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // First requesting index found walking from 'start' with wrap-around,
  // skipping index 'skip'. Returns -1 when none is found.
  function automatic int find_req(input logic [N_REQ-1:0] r, input int start,
                                  input int skip);
    int i;
    for (int k = 0; k < N_REQ; k++) begin
      i = (start + k) % N_REQ;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int nxt;
    if (rst) begin
      m_t = 0; m_owner = -1; m_slice = 0; m_rr = 0; m_word = '0;
      return;
    end
    if (m_t == FRAME - 1) begin
      if (m_owner < 0) begin
        nxt = find_req(req, m_rr, -1);
        m_slice = 0;
      end else if (!req[m_owner]) begin
        nxt = find_req(req, (m_owner + 1) % N_REQ, m_owner);
        m_slice = 0;
      end else if (m_slice == SLICE_FRAMES - 1) begin
        nxt = find_req(req, (m_owner + 1) % N_REQ, m_owner);
        if (nxt < 0) nxt = m_owner;
        m_slice = 0;
      end else begin
        nxt = m_owner;
        m_slice++;
      end
      m_owner = nxt;
      if (nxt >= 0) begin
        m_rr   = (nxt + 1) % N_REQ;
        m_word = data[16*nxt +: 16];
      end else begin
        m_word = '0;
      end
    end
    m_t = (m_t + 1) % FRAME;
  endtask

  task automatic compare_all();
    int         dig;
    int         pos;
    logic [3:0] eg;
    logic [3:0] ea;
    logic [3:0] eb;
    dig = m_t / SCAN_DIV;
    pos = m_t % SCAN_DIV;
    eg  = (m_owner < 0) ? 4'h0 : 4'(1 << m_owner);
    ea  = (m_owner < 0 || pos < BLANK_CYC) ? 4'hF : ~4'(1 << dig);
    eb  = 4'((m_word >> (4 * dig)) & 16'hF);
    check_eq({phase, "_grant"}, 32'(grant), 32'(eg));
    check_eq({phase, "_an"},    32'(an),    32'(ea));
    check_eq({phase, "_bcd"},   32'(digit_bcd), 32'(eb));
    check_eq({phase, "_dp"},    32'(dp), 32'd1);
    check_eq({phase, "_tick"},  32'(frame_tick), 32'(m_t == FRAME - 1));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Advance until the model sits at the given in-frame index.
  task automatic run_to(input int target);
    int n;
    n = 0;
    while (m_t != target && n < 2 * FRAME) begin
      step();
      n++;
    end
  endtask

  // Cross the next frame boundary; afterwards m_t == 0.
  task automatic next_frame();
    run_to(FRAME - 1);
    step();
  endtask

  int exp3 [5] = '{1, 1, 4, 4, 1};
  int lat;
  int ri;

  initial begin
    m_t = 0; m_owner = -1; m_slice = 0; m_rr = 0; m_word = '0;

    // Reset, then idle.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    phase = "p1";
    for (int k = 0; k < 100; k++) begin
      check_eq("p1_tick_cycle", 32'(frame_tick),
               32'((k == 31) || (k == 63) || (k == 95)));
      check_eq("p1_an_idle", 32'(an), 32'hF);
      step();
    end
    $display("phase p1 idle scan done checks=%0d", checks);

    // Single requester 1 with 0x1234.
    phase = "p2";
    req = 4'b0010;
    data[31:16] = 16'h1234;
    next_frame();
    check_eq("p2_grant", 32'(grant), 32'h2);
    check_eq("p2_an_blank", 32'(an), 32'hF);
    run_to(2);
    check_eq("p2_an_d0", 32'(an), 32'hE);
    check_eq("p2_bcd_d0", 32'(digit_bcd), 32'h4);
    run_to(26);
    check_eq("p2_an_d3", 32'(an), 32'h7);
    check_eq("p2_bcd_d3", 32'(digit_bcd), 32'h1);
    $display("phase p2 single owner done checks=%0d", checks);

    // Round-robin between 0 and 2 after a fresh reset.
    phase = "p3";
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0101;
    for (int f = 0; f < 5; f++) begin
      next_frame();
      check_eq("p3_rr_grant", 32'(grant), 32'(exp3[f]));
    end
    req = 4'b0001;
    for (int f = 0; f < 4; f++) begin
      next_frame();
      check_eq("p3_hold_grant", 32'(grant), 32'h1);
    end
    $display("phase p3 round robin done checks=%0d", checks);

    // A mid-frame data change is not visible until the next frame.
    phase = "p4";
    data[15:0] = 16'h5678;
    next_frame();
    run_to(9);
    data[15:0] = 16'h9999;
    run_to(18);
    check_eq("p4_bcd_d2_old", 32'(digit_bcd), 32'h6);
    run_to(26);
    check_eq("p4_bcd_d3_old", 32'(digit_bcd), 32'h5);
    next_frame();
    for (int d = 0; d < 4; d++) begin
      run_to(d * SCAN_DIV + BLANK_CYC);
      check_eq("p4_bcd_new", 32'(digit_bcd), 32'h9);
    end
    $display("phase p4 tear-free latch done checks=%0d", checks);

    // Owner drops its request with requester 3 waiting; then everyone drops.
    phase = "p5";
    req = 4'b1000;
    next_frame();
    check_eq("p5_grant_handoff", 32'(grant), 32'h8);
    run_to(2);
    check_eq("p5_an_no_gap", 32'(an), 32'hE);
    req = 4'b0000;
    next_frame();
    check_eq("p5_grant_idle", 32'(grant), 32'h0);
    run_to(2);
    check_eq("p5_an_idle", 32'(an), 32'hF);
    $display("phase p5 drop handling done checks=%0d", checks);

    // Reset in the middle of the digit 2 slot while requester 1 owns.
    phase = "p6";
    req = 4'b0010;
    next_frame();
    check_eq("p6_grant_pre", 32'(grant), 32'h2);
    run_to(2 * SCAN_DIV + 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("p6_grant_rst", 32'(grant), 32'h0);
    check_eq("p6_an_rst", 32'(an), 32'hF);
    check_eq("p6_bcd_rst", 32'(digit_bcd), 32'h0);
    lat = 0;
    while (!frame_tick && lat < 3 * FRAME) begin
      step();
      lat++;
    end
    check_eq("p6_tick_latency", 32'(lat), 32'd31);
    $display("phase p6 mid-frame reset done checks=%0d", checks);

    // Randomized traffic, with occasional resets.
    phase = "rnd";
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        ri = $urandom_range(0, N_REQ - 1);
        data[16*ri +: 16] = 16'($urandom);
      end
      if ($urandom_range(0, 699) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    $display("phase rnd random traffic done checks=%0d", checks);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
